port_ring_launch: RTL and testbench

Ring launcher for one bridge port. It pairs each forwarding-lookup result (destination port vector) with the matching packet from the port receive FIFO and emits the packet onto the local ring-tap injection channel. The emitted packet is a command word carrying the destination vector, followed by the data words. It sits directly upstream of the port's ring tap FSM and drives that FSM's `lfli_*` inputs.

---
 rtl/port_ring_launch.sv | 260 ++++++++++++++++++++++++++
 tb/tb_port_ring_launch.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_ring_launch.sv
// Ring launcher: pairs lookup port vectors with receive-FIFO packets
// and injects {command word, data words} onto the local ring tap.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   lkr_*             lookup result channel (srdy/drdy, pvec)
//   prx_*             receive word channel (srdy/drdy, data)
//   lfli_*            ring tap injection channel (srdy/drdy, data)
//   pkt_cnt           packets launched
//   drop_cnt          packets dropped (no destination besides self)
//   trunc_cnt         packets truncated at max_words
//
// Build option: define PORT_RING_LAUNCH_STATS_EN to implement the
// three statistics counters; otherwise they read as constant 0.

module port_ring_launch #(
  parameter int rdp_sz    = 64,
  parameter int num_ports = 4,
  parameter int portnum   = 0,
  parameter int max_words = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lkr_srdy,
  output logic                 lkr_drdy,
  input  logic [num_ports-1:0] lkr_pvec,
  input  logic                 prx_srdy,
  output logic                 prx_drdy,
  input  logic [rdp_sz-1:0]    prx_data,
  output logic                 lfli_srdy,
  input  logic                 lfli_drdy,
  output logic [rdp_sz-1:0]    lfli_data,
  output logic [15:0]          pkt_cnt,
  output logic [15:0]          drop_cnt,
  output logic [15:0]          trunc_cnt
);

  localparam int cw = $clog2(max_words) + 1;

  localparam logic [num_ports-1:0] port_mask =
    num_ports'(1) << portnum;

  typedef enum logic [1:0] {
    s_idle,
    s_data,
    s_drop
  } state_e;

  state_e state_q;
  state_e state_d;

  logic [cw-1:0]        cnt_q;
  logic [cw-1:0]        cnt_d;
  logic                 ovld_q;
  logic                 ovld_d;
  logic [rdp_sz-1:0]    odata_q;
  logic [rdp_sz-1:0]    odata_d;

  logic [num_ports-1:0] eff;
  logic                 eff_zero;
  logic                 oready;
  logic                 eop_in;
  logic [cw-1:0]        cnt_inc;
  logic                 cnt_full;
  logic [rdp_sz-1:0]    cmd_word;
  logic [rdp_sz-1:0]    data_word;

  logic                 ld_cmd;
  logic                 ld_data;
  logic                 inc_pkt;
  logic                 inc_drop;
  logic                 inc_trunc;

  // ---------------------------------------------------------------
  // Shared decode
  // ---------------------------------------------------------------
  assign eff      = lkr_pvec & ~port_mask;
  assign eff_zero = (eff == '0);
  assign oready   = ~ovld_q | lfli_drdy;
  assign eop_in   = prx_data[rdp_sz-2];
  assign cnt_inc  = cnt_q + cw'(1);
  assign cnt_full = (cnt_inc == cw'(max_words));

  always_comb begin
    cmd_word                = '0;
    cmd_word[rdp_sz-1]      = 1'b1;
    cmd_word[num_ports-1:0] = eff;
  end

  // Data words never carry the PVEC flag; the word that hits the
  // length limit gets EOP so the ring sees a closed packet.
  always_comb begin
    data_word           = prx_data;
    data_word[rdp_sz-1] = 1'b0;
    data_word[rdp_sz-2] = eop_in | cnt_full;
  end

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= s_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      s_idle: begin
        if (lkr_srdy) begin
          if (eff_zero) begin
            state_d = s_drop;
          end else if (oready) begin
            state_d = s_data;
          end
        end
      end
      s_data: begin
        if (prx_srdy & oready) begin
          if (eop_in) begin
            state_d = s_idle;
          end else if (cnt_full) begin
            state_d = s_drop;
          end
        end
      end
      s_drop: begin
        if (prx_srdy & eop_in) begin
          state_d = s_idle;
        end
      end
      default: begin
        state_d = s_idle;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------
  always_comb begin
    lkr_drdy  = 1'b0;
    prx_drdy  = 1'b0;
    ld_cmd    = 1'b0;
    ld_data   = 1'b0;
    inc_pkt   = 1'b0;
    inc_drop  = 1'b0;
    inc_trunc = 1'b0;
    unique case (state_q)
      s_idle: begin
        // A self-only lookup is retired even when the output
        // register is busy, since it produces no ring word.
        if (lkr_srdy) begin
          if (eff_zero) begin
            lkr_drdy = 1'b1;
            inc_drop = 1'b1;
          end else if (oready) begin
            lkr_drdy = 1'b1;
            ld_cmd   = 1'b1;
            inc_pkt  = 1'b1;
          end
        end
      end
      s_data: begin
        prx_drdy  = oready;
        ld_data   = prx_srdy & oready;
        inc_trunc = ld_data & ~eop_in & cnt_full;
      end
      s_drop: begin
        prx_drdy = 1'b1;
      end
      default: begin
        prx_drdy = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Output register and word counter
  // ---------------------------------------------------------------
  always_comb begin
    cnt_d   = cnt_q;
    ovld_d  = ovld_q;
    odata_d = odata_q;
    if (lfli_drdy) begin
      ovld_d = 1'b0;
    end
    if (ld_cmd) begin
      cnt_d   = '0;
      ovld_d  = 1'b1;
      odata_d = cmd_word;
    end else if (ld_data) begin
      cnt_d   = cnt_inc;
      ovld_d  = 1'b1;
      odata_d = data_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      ovld_q  <= 1'b0;
      odata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ovld_q  <= ovld_d;
      odata_q <= odata_d;
    end
  end

  assign lfli_srdy = ovld_q;
  assign lfli_data = odata_q;

  // ---------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------
`ifdef PORT_RING_LAUNCH_STATS_EN
  logic [15:0] pkt_cnt_q;
  logic [15:0] pkt_cnt_d;
  logic [15:0] drop_cnt_q;
  logic [15:0] drop_cnt_d;
  logic [15:0] trunc_cnt_q;
  logic [15:0] trunc_cnt_d;

  always_comb begin
    pkt_cnt_d   = pkt_cnt_q + {15'd0, inc_pkt};
    drop_cnt_d  = drop_cnt_q + {15'd0, inc_drop};
    trunc_cnt_d = trunc_cnt_q + {15'd0, inc_trunc};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      trunc_cnt_q <= '0;
    end else begin
      pkt_cnt_q   <= pkt_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end

  assign pkt_cnt   = pkt_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign trunc_cnt = trunc_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = inc_pkt | inc_drop | inc_trunc;
  assign pkt_cnt      = '0;
  assign drop_cnt     = '0;
  assign trunc_cnt    = '0;
`endif

endmodule

// File: tb/tb_port_ring_launch.sv
// Testbench for port_ring_launch: packet-level reference model,
// randomized handshakes, scoreboard on the ring tap channel.
`timescale 1ns/1ps

module tb_port_ring_launch;

  localparam int RDP  = 16;
  localparam int NP   = 4;
  localparam int PN   = 0;
  localparam int MAXW = 4;

`ifdef PORT_RING_LAUNCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           lkr_srdy = 1'b0;
  logic           lkr_drdy;
  logic [NP-1:0]  lkr_pvec = '0;
  logic           prx_srdy = 1'b0;
  logic           prx_drdy;
  logic [RDP-1:0] prx_data = '0;
  logic           lfli_srdy;
  logic           lfli_drdy = 1'b0;
  logic [RDP-1:0] lfli_data;
  logic [15:0]    pkt_cnt;
  logic [15:0]    drop_cnt;
  logic [15:0]    trunc_cnt;

  port_ring_launch #(
    .rdp_sz(RDP),
    .num_ports(NP),
    .portnum(PN),
    .max_words(MAXW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .lkr_srdy(lkr_srdy),
    .lkr_drdy(lkr_drdy),
    .lkr_pvec(lkr_pvec),
    .prx_srdy(prx_srdy),
    .prx_drdy(prx_drdy),
    .prx_data(prx_data),
    .lfli_srdy(lfli_srdy),
    .lfli_drdy(lfli_drdy),
    .lfli_data(lfli_data),
    .pkt_cnt(pkt_cnt),
    .drop_cnt(drop_cnt),
    .trunc_cnt(trunc_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [RDP-1:0] exp_q[$];
  logic [NP-1:0]  lkq[$];
  logic [RDP-1:0] wq[$];
  int             out_cyc[$];
  int             lk_cyc = 0;
  logic [15:0]    m_pkt = '0;
  logic [15:0]    m_drop = '0;
  logic [15:0]    m_trunc = '0;
  int             n_checks = 0;
  int             n_fail = 0;
  int             sink_mode = 0;
  bit             gaps = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Packet-level model: what the ring must see for one packet.
  task automatic add_pkt(input logic [NP-1:0] pv, input int len);
    logic [NP-1:0]  eff;
    logic [RDP-1:0] w;
    logic [RDP-1:0] cmd;
    logic [RDP-1:0] ws[$];
    eff = pv & ~NP'(1 << PN);
    lkq.push_back(pv);
    for (int k = 0; k < len; k++) begin
      w = RDP'($urandom);
      w[RDP-2] = (k == len - 1);
      ws.push_back(w);
      wq.push_back(w);
    end
    if (eff == '0) begin
      m_drop++;
      return;
    end
    cmd = '0;
    cmd[RDP-1] = 1'b1;
    cmd[NP-1:0] = eff;
    exp_q.push_back(cmd);
    m_pkt++;
    for (int k = 0; k < len; k++) begin
      w = ws[k];
      w[RDP-1] = 1'b0;
      if (k == len - 1) begin
        exp_q.push_back(w);
        break;
      end
      if (k + 1 == MAXW) begin
        w[RDP-2] = 1'b1;
        exp_q.push_back(w);
        m_trunc++;
        break;
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic drive_lkr();
    int n;
    bit acc;
    while (lkq.size() != 0) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      lkr_pvec = lkq.pop_front();
      lkr_srdy = 1'b1;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 300) begin
        @(negedge clk);
        acc = lkr_drdy;
        if (acc) lk_cyc = cyc;
        @(posedge clk); #1;
        n++;
      end
      lkr_srdy = 1'b0;
      chk("lkr_accept", 32'(acc), 32'd1);
    end
  endtask

  task automatic drive_prx();
    int n;
    bit acc;
    while (wq.size() != 0) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      prx_data = wq.pop_front();
      prx_srdy = 1'b1;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 300) begin
        @(negedge clk);
        acc = prx_drdy;
        @(posedge clk); #1;
        n++;
      end
      prx_srdy = 1'b0;
      chk("prx_accept", 32'(acc), 32'd1);
    end
  endtask

  task automatic check_cnts(input string nm);
    chk({nm, " pkt_cnt"}, 32'(pkt_cnt), STATS ? 32'(m_pkt) : 32'd0);
    chk({nm, " drop_cnt"}, 32'(drop_cnt), STATS ? 32'(m_drop) : 32'd0);
    chk({nm, " trunc_cnt"}, 32'(trunc_cnt),
        STATS ? 32'(m_trunc) : 32'd0);
  endtask

  task automatic run_batch(input string nm);
    int n;
    fork
      drive_lkr();
      drive_prx();
    join
    n = 0;
    while ((exp_q.size() != 0 || lfli_srdy) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " drained"}, 32'(exp_q.size()), 32'd0);
    chk({nm, " idle srdy"}, 32'(lfli_srdy), 32'd0);
    check_cnts(nm);
  endtask

  // Ring-side sink
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk); #1;
      case (sink_mode)
        0: lfli_drdy = 1'b1;
        1: lfli_drdy = (ph % 3 == 0);
        2: lfli_drdy = 1'($urandom_range(0, 1));
        default: lfli_drdy = 1'b0;
      endcase
      ph++;
    end
  end

  // Compare process: every transfer against the model, plus
  // hold-stability of a stalled output word.
  logic           stall_prev = 1'b0;
  logic [RDP-1:0] data_prev = '0;

  always @(negedge clk) begin
    if (reset) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall srdy held", 32'(lfli_srdy), 32'd1);
        chk("stall data held", 32'(lfli_data), 32'(data_prev));
      end
      if (lfli_srdy && lfli_drdy) begin
        out_cyc.push_back(cyc);
        chk("word expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          chk("ring word", 32'(lfli_data), 32'(exp_q.pop_front()));
        end
      end
      stall_prev <= lfli_srdy & ~lfli_drdy;
      data_prev  <= lfli_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RDP-1:0] w;
    logic [RDP-1:0] cmd;

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst lfli_srdy", 32'(lfli_srdy), 32'd0);
    chk("rst lfli_data", 32'(lfli_data), 32'd0);
    chk("rst lkr_drdy", 32'(lkr_drdy), 32'd0);
    chk("rst prx_drdy", 32'(prx_drdy), 32'd0);
    check_cnts("rst");
    @(posedge clk); #1;

    // Basic launch, with literal pins on the model
    sink_mode = 0;
    gaps = 1'b0;
    @(posedge clk); #1;
    add_pkt(4'b0110, 3);
    chk("basic model len", 32'(exp_q.size()), 32'd4);
    chk("basic model cmd", 32'(exp_q[0]), 32'h8006);
    chk("basic model eop", 32'(exp_q[3][RDP-2]), 32'd1);
    out_cyc.delete();
    run_batch("basic");
    chk("basic out count", 32'(out_cyc.size()), 32'd4);
    if (out_cyc.size() == 4) begin
      chk("basic cmd latency", 32'(out_cyc[0]), 32'(lk_cyc + 1));
      chk("basic last cycle", 32'(out_cyc[3]), 32'(lk_cyc + 4));
    end
    chk("basic pkt literal", 32'(pkt_cnt), STATS ? 32'd1 : 32'd0);

    // Self-only drop followed by a normal packet
    add_pkt(4'b0001, 5);
    add_pkt(4'b0010, 3);
    chk("drop model len", 32'(exp_q.size()), 32'd4);
    run_batch("drop");
    chk("drop literal", 32'(drop_cnt), STATS ? 32'd1 : 32'd0);

    // Truncation at MAXW
    add_pkt(4'b1000, 7);
    chk("trunc model len", 32'(exp_q.size()), 32'd5);
    run_batch("trunc");
    chk("trunc literal", 32'(trunc_cnt), STATS ? 32'd1 : 32'd0);

    // Backpressure 1,0,0 pattern
    sink_mode = 1;
    add_pkt(4'b0100, 6);
    add_pkt(4'b1110, 3);
    run_batch("bp");

    // Reset mid-packet with a stalled output word
    sink_mode = 0;
    @(posedge clk); #1;
    lkq.push_back(4'b0010);
    cmd = '0;
    cmd[RDP-1] = 1'b1;
    cmd[1] = 1'b1;
    exp_q.push_back(cmd);
    for (int k = 0; k < 2; k++) begin
      w = RDP'($urandom);
      w[RDP-2] = 1'b0;
      wq.push_back(w);
      w[RDP-1] = 1'b0;
      exp_q.push_back(w);
    end
    fork
      drive_lkr();
      drive_prx();
    join
    sink_mode = 3;
    lfli_drdy = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    prx_data = RDP'($urandom);
    prx_srdy = 1'b1;
    exp_q.delete();
    m_pkt = '0;
    m_drop = '0;
    m_trunc = '0;
    @(negedge clk);
    chk("mid rst lfli_srdy", 32'(lfli_srdy), 32'd0);
    chk("mid rst prx_drdy", 32'(prx_drdy), 32'd0);
    check_cnts("mid rst");
    @(posedge clk); #1;
    prx_srdy = 1'b0;
    sink_mode = 0;
    @(posedge clk); #1;

`ifdef PORT_RING_LAUNCH_STATS_EN
    force dut.pkt_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.pkt_cnt_q;
    m_pkt = 16'hFFFF;
    add_pkt(4'b0100, 2);
    run_batch("wrap");
    chk("wrap literal", 32'(pkt_cnt), 32'h0000);
`endif

    // Randomized traffic
    sink_mode = 2;
    gaps = 1'b1;
    for (int b = 0; b < 6; b++) begin
      for (int p = 0; p < 8; p++) begin
        add_pkt(NP'($urandom_range(0, 15)), $urandom_range(1, 9));
      end
      run_batch("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
